// File: rtl/debug_unit_pkg.sv
// Shared definitions for the debug front end.
// Command bytes, FSM state encoding and the counter helper.
package debug_unit_pkg;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h43;
  localparam logic [7:0] CMD_STEP = 8'h53;
  localparam logic [7:0] CMD_DUMP = 8'h44;

  localparam logic [31:0] HALT_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_LEN,
    S_LOAD_DATA,
    S_RUN,
    S_DRAIN,
    S_STEP,
    S_SNAP,
    S_SEND
  } dbg_state_t;

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v
  );
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/debug_unit_if.sv
// UART byte link between host side and debug unit.
// rx is a one-cycle strobe; tx is a valid/ready handshake.
interface debug_unit_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid
  );

  modport slave (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid
  );
endinterface

// File: rtl/debug_unit_tx_serializer.sv
// Snapshot word array to MSB-first byte stream.
// Word 0 sits in the LSBs of words and is sent first.
module debug_tx_serializer #(
  parameter int WORDS = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [32*WORDS-1:0]  words,
  input  logic                 tx_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic                 done
);
  localparam int NB = 4 * WORDS;
  localparam int IW = $clog2(NB);

  logic [IW-1:0] idx;
  logic          last;
  logic [31:0]   word;
  logic [7:0]    sel;

  always_comb begin
    last = (idx == IW'(NB - 1));
    word = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (idx[IW-1:2] == (IW-2)'(i))
        word = words[32*i +: 32];
    end
    sel = '0;
    unique case (idx[1:0])
      2'd0: sel = word[31:24];
      2'd1: sel = word[23:16];
      2'd2: sel = word[15:8];
      2'd3: sel = word[7:0];
      default: sel = '0;
    endcase
    tx_data = tx_valid ? sel : 8'h00;
    done    = tx_valid && tx_ready && last;
  end

  // tx_valid stays up until the final byte is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_valid <= 1'b0;
      idx      <= '0;
    end else if (start) begin
      tx_valid <= 1'b1;
      idx      <= '0;
    end else if (tx_valid && tx_ready) begin
      if (last)
        tx_valid <= 1'b0;
      else
        idx <= idx + IW'(1);
    end
  end

endmodule

// File: rtl/debug_unit.sv
// Byte-command front end: loads imem, runs or steps the
// pipeline through pipe_en, and streams a state snapshot back.
module debug_unit
  import debug_unit_pkg::*;
#(
  parameter int          IMEM_ADDR_W  = 8,
  parameter int          DUMP_WORDS   = 5,
  parameter logic [31:0] HALT_INSTR   = HALT_DEFAULT,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  debug_unit_if.slave              link,
  output logic                     imem_we,
  output logic [IMEM_ADDR_W-1:0]   imem_addr,
  output logic [31:0]              imem_wdata,
  output logic                     pipe_en,
  output logic                     pipe_rst,
  input  logic [31:0]              instr_if,
  input  logic [31:0]              pc_if,
  input  logic [32*DUMP_WORDS-1:0] dump_bus,
  output logic                     busy
);
  localparam int SW  = 2 + DUMP_WORDS;
  localparam int DRW = $clog2(DRAIN_CYCLES + 1);

  dbg_state_t         state, state_nx;
  logic [31:0]        cnt;
  logic [23:0]        asm_q;
  logic [1:0]         byte_idx;
  logic [7:0]         words_left;
  logic [DRW-1:0]     drain_q;
  logic [32*SW-1:0]   snap;
  logic               rx_cmd;
  logic               cmd_load;
  logic               cmd_run;
  logic               cmd_step;
  logic               cmd_dump;
  logic               word_done;
  logic               snap_start;
  logic               tx_done;

  always_comb begin
    rx_cmd    = (state == S_IDLE) && link.rx_valid;
    cmd_load  = rx_cmd && (link.rx_data == CMD_LOAD);
    cmd_run   = rx_cmd && (link.rx_data == CMD_RUN);
    cmd_step  = rx_cmd && (link.rx_data == CMD_STEP);
    cmd_dump  = rx_cmd && (link.rx_data == CMD_DUMP);
    word_done = (state == S_LOAD_DATA) && link.rx_valid
                && (byte_idx == 2'd3);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        unique case (1'b1)
          cmd_load: state_nx = S_LOAD_LEN;
          cmd_run:  state_nx = S_RUN;
          cmd_step: state_nx = S_STEP;
          cmd_dump: state_nx = S_SNAP;
          default:  state_nx = S_IDLE;
        endcase
      end
      S_LOAD_LEN:
        if (link.rx_valid)
          state_nx = (link.rx_data == 8'd0) ? S_IDLE : S_LOAD_DATA;
      S_LOAD_DATA:
        if (imem_we && words_left == 8'd1)
          state_nx = S_IDLE;
      S_RUN:
        if (instr_if == HALT_INSTR)
          state_nx = S_DRAIN;
      S_DRAIN:
        if (drain_q == DRW'(DRAIN_CYCLES - 1))
          state_nx = S_SNAP;
      S_STEP:  state_nx = S_SNAP;
      S_SNAP:  state_nx = S_SEND;
      S_SEND:
        if (tx_done)
          state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    pipe_en = 1'b0;
    unique case (state)
      S_RUN, S_DRAIN, S_STEP: pipe_en = 1'b1;
      default:                pipe_en = 1'b0;
    endcase
    busy       = (state != S_IDLE);
    snap_start = (state == S_SNAP);
  end

  // a byte may land while the previous word's write is still in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_rst   <= 1'b1;
      cnt        <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      asm_q      <= '0;
      byte_idx   <= '0;
      words_left <= '0;
      drain_q    <= '0;
    end else begin
      pipe_rst <= (state_nx == S_LOAD_LEN)
                  || (state_nx == S_LOAD_DATA);
      imem_we  <= word_done;
      if (word_done)
        imem_wdata <= {asm_q, link.rx_data};
      if (state == S_LOAD_DATA && link.rx_valid) begin
        asm_q    <= {asm_q[15:0], link.rx_data};
        byte_idx <= byte_idx + 2'd1;
      end
      if (cmd_load) begin
        imem_addr <= '0;
        byte_idx  <= '0;
        cnt       <= '0;
      end else begin
        if (imem_we)
          imem_addr <= imem_addr + IMEM_ADDR_W'(1);
        if (pipe_en)
          cnt <= sat_inc(cnt);
      end
      if (state == S_LOAD_LEN && link.rx_valid)
        words_left <= link.rx_data;
      else if (imem_we)
        words_left <= words_left - 8'd1;
      if (state == S_RUN)
        drain_q <= '0;
      else if (state == S_DRAIN)
        drain_q <= drain_q + DRW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      snap <= '0;
    else if (snap_start)
      snap <= {dump_bus, pc_if, cnt};
  end

  debug_tx_serializer #(
    .WORDS (SW)
  ) u_tx (
    .clk      (clk),
    .reset    (reset),
    .start    (snap_start),
    .words    (snap),
    .tx_ready (link.tx_ready),
    .tx_data  (link.tx_data),
    .tx_valid (link.tx_valid),
    .done     (tx_done)
  );

endmodule

// File: tb/tb_debug_unit.sv
// Testbench for debug_unit: random stimulus against a
// command-level model of loads, cycle counts and dump bytes.
module tb_debug_unit;
  import debug_unit_pkg::*;

  localparam int AW = 8;
  localparam int DW = 5;
  localparam int NB = 4 * (2 + DW);
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic imem_we, pipe_en, pipe_rst, busy;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [31:0] instr_if = 32'h0;
  logic [31:0] pc_if = 32'h0;
  logic [32*DW-1:0] dump_bus = '0;

  debug_unit_if link();

  debug_unit #(
    .IMEM_ADDR_W  (AW),
    .DUMP_WORDS   (DW),
    .HALT_INSTR   (HALT),
    .DRAIN_CYCLES (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .link       (link),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .pipe_en    (pipe_en),
    .pipe_rst   (pipe_rst),
    .instr_if   (instr_if),
    .pc_if      (pc_if),
    .dump_bus   (dump_bus),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  longint m_cnt = 0;
  logic [7:0] exp_b [NB];

  // monitor state, written only by the monitor process
  int en_cnt = 0;
  int en_in_tx = 0;
  logic [7:0] tx_q [$];
  logic [AW-1:0] wa_q [$];
  logic [31:0] wd_q [$];
  logic wr_rst_q [$];

  // controls, written only by the initial block
  bit arm = 0;
  int run_base = 0;
  int halt_at = 0;
  bit rand_ready = 0;
  bit force_low = 0;

  always @(negedge clk) begin
    if (imem_we) begin
      wa_q.push_back(imem_addr);
      wd_q.push_back(imem_wdata);
      wr_rst_q.push_back(pipe_rst);
    end
    if (link.tx_valid && link.tx_ready)
      tx_q.push_back(link.tx_data);
    if (pipe_en) en_cnt++;
    if (pipe_en && link.tx_valid) en_in_tx++;
    if (arm && (en_cnt - run_base) >= halt_at)
      instr_if = HALT;
    else
      instr_if = {1'b0, 31'($urandom)};
  end

  always begin
    @(posedge clk);
    #2;
    if (force_low)
      link.tx_ready = 1'b0;
    else if (rand_ready)
      link.tx_ready = 1'($urandom_range(0, 1));
    else
      link.tx_ready = 1'b1;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_rx(input logic [7:0] b, input int gap);
    link.rx_data = b;
    link.rx_valid = 1'b1;
    tick(1);
    link.rx_valid = 1'b0;
    link.rx_data = 8'($urandom);
    tick(gap);
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      if (!busy) begin
        ok = 1;
        break;
      end
      tick(1);
    end
  endtask

  task automatic build_exp(input logic [31:0] c);
    logic [31:0] w;
    for (int k = 0; k < 2 + DW; k++) begin
      if (k == 0) w = c;
      else if (k == 1) w = pc_if;
      else w = dump_bus[32*(k-2) +: 32];
      for (int j = 0; j < 4; j++)
        exp_b[4*k+j] = 8'(w >> (24 - 8*j));
    end
  endtask

  task automatic randomize_state();
    pc_if = $urandom;
    for (int i = 0; i < DW; i++)
      dump_bus[32*i +: 32] = $urandom;
  endtask

  task automatic test_reset();
    logic [44:0] obs;
    logic [44:0] exp;
    reset = 1'b0;
    tick(2);
    obs = {link.tx_valid, link.tx_data, imem_we, pipe_en,
           pipe_rst, busy, imem_wdata};
    exp = {1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0};
    checks++;
    if (obs !== exp || imem_addr !== '0) begin
      errors++;
      $display("FAIL reset_state got %h addr %h want %h addr 0",
               obs, imem_addr, exp);
    end
    @(negedge clk);
    reset = 1'b1;
    tick(1);
    checks++;
    if (pipe_rst !== 1'b0) begin
      errors++;
      $display("FAIL reset_release pipe_rst got %b want 0", pipe_rst);
    end
  endtask

  task automatic test_load(input int n, input logic [31:0] w [16]);
    int base;
    bit ok;
    base = wa_q.size();
    send_rx(CMD_LOAD, $urandom_range(0, 3));
    send_rx(8'(n), $urandom_range(0, 3));
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 4; j++)
        send_rx(8'(w[i] >> (24 - 8*j)), $urandom_range(0, 3));
    wait_idle(20, ok);
    tick(2);
    m_cnt = 0;
    checks++;
    if (wa_q.size() - base != n) begin
      errors++;
      $display("FAIL load_count got %0d want %0d",
               wa_q.size() - base, n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (base + i >= wa_q.size()) begin
        errors++;
        $display("FAIL load_word%0d got none want %h", i, w[i]);
      end else if (wa_q[base+i] !== AW'(i) || wd_q[base+i] !== w[i]
                   || wr_rst_q[base+i] !== 1'b1) begin
        errors++;
        $display("FAIL load_word%0d got %h@%0d rst %b want %h@%0d rst 1",
                 i, wd_q[base+i], wa_q[base+i], wr_rst_q[base+i],
                 w[i], i);
      end
    end
    checks++;
    if (!ok || busy !== 1'b0 || pipe_rst !== 1'b0) begin
      errors++;
      $display("FAIL load_end got busy %b pipe_rst %b want 0 0",
               busy, pipe_rst);
    end
  endtask

  task automatic test_edge_cmds();
    int base_w;
    int base_e;
    base_w = wa_q.size();
    base_e = en_cnt;
    send_rx(CMD_LOAD, 1);
    send_rx(8'h00, 2);
    m_cnt = 0;
    checks++;
    if (wa_q.size() != base_w || busy !== 1'b0 || pipe_rst !== 1'b0) begin
      errors++;
      $display("FAIL load_zero got writes %0d busy %b rst %b want 0 0 0",
               wa_q.size() - base_w, busy, pipe_rst);
    end
    send_rx(8'h58, 0);
    tick(2);
    checks++;
    if (busy !== 1'b0 || en_cnt != base_e || link.tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL ignore_X got busy %b en %0d tx %b want 0 0 0",
               busy, en_cnt - base_e, link.tx_valid);
    end
  endtask

  task automatic test_dump_cmd(input string name, input logic [7:0] cmd,
                               input int want_en);
    int base_e;
    int base_t;
    int base_x;
    int bad;
    bit ok;
    base_e = en_cnt;
    base_t = tx_q.size();
    base_x = en_in_tx;
    send_rx(cmd, 0);
    if (cmd == CMD_RUN) begin
      send_rx(CMD_LOAD, 0);
      send_rx(CMD_STEP, 0);
    end
    wait_idle(2000, ok);
    m_cnt += want_en;
    build_exp(32'(m_cnt));
    checks++;
    if (!ok || en_cnt - base_e != want_en || en_in_tx != base_x) begin
      errors++;
      $display("FAIL %s_enable got %0d idle %b en_tx %0d want %0d 1 0",
               name, en_cnt - base_e, ok, en_in_tx - base_x, want_en);
    end
    checks++;
    if (tx_q.size() - base_t != NB) begin
      errors++;
      $display("FAIL %s_bytes got %0d want %0d",
               name, tx_q.size() - base_t, NB);
    end
    bad = -1;
    for (int i = NB - 1; i >= 0; i--)
      if (base_t + i >= tx_q.size() || tx_q[base_t+i] !== exp_b[i])
        bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s_data byte %0d got %h want %h", name, bad,
               (base_t + bad < tx_q.size()) ? tx_q[base_t+bad] : 8'hxx,
               exp_b[bad]);
    end
  endtask

  task automatic test_step(input logic [31:0] pc);
    randomize_state();
    pc_if = pc;
    test_dump_cmd("step", CMD_STEP, 1);
  endtask

  task automatic test_run(input int h);
    randomize_state();
    halt_at = h;
    run_base = en_cnt;
    arm = 1;
    test_dump_cmd("run", CMD_RUN, h + 4);
    arm = 0;
  endtask

  task automatic test_dump_random_ready();
    randomize_state();
    rand_ready = 1;
    test_dump_cmd("dump", CMD_DUMP, 0);
    rand_ready = 0;
  endtask

  task automatic test_backpressure();
    int base_t;
    int stalls;
    int bad;
    bit ok;
    logic [7:0] held;
    randomize_state();
    base_t = tx_q.size();
    send_rx(CMD_DUMP, 0);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx_q.size() - base_t == 7) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    force_low = 1;
    held = link.tx_data;
    stalls = 0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (link.tx_valid !== 1'b1 || link.tx_data !== held) stalls++;
    end
    build_exp(32'(m_cnt));
    checks++;
    if (!ok || stalls != 0 || held !== exp_b[7]) begin
      errors++;
      $display("FAIL bp_hold got %h unstable %0d reached %b want %h 0 1",
               held, stalls, ok, exp_b[7]);
    end
    force_low = 0;
    wait_idle(200, ok);
    bad = 0;
    for (int i = 0; i < NB; i++)
      if (base_t + i >= tx_q.size() || tx_q[base_t+i] !== exp_b[i])
        bad++;
    checks++;
    if (!ok || tx_q.size() - base_t != NB || bad != 0) begin
      errors++;
      $display("FAIL bp_total got %0d bytes %0d wrong want %0d 0",
               tx_q.size() - base_t, bad, NB);
    end
  endtask

  task automatic test_reset_mid_send();
    int base_t;
    bit ok;
    randomize_state();
    base_t = tx_q.size();
    send_rx(CMD_DUMP, 0);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx_q.size() - base_t == 3) begin
        ok = 1;
        break;
      end
      tick(1);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (!ok || link.tx_valid !== 1'b0 || busy !== 1'b0
        || pipe_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_send got tx %b busy %b en %b reached %b want 0 0 0 1",
               link.tx_valid, busy, pipe_en, ok);
    end
    @(negedge clk);
    reset = 1'b1;
    m_cnt = 0;
    tick(2);
    test_dump_cmd("post_reset", CMD_DUMP, 0);
  endtask

  initial begin
    logic [31:0] w [16];
    link.rx_data = 8'h00;
    link.rx_valid = 1'b0;
    link.tx_ready = 1'b1;
    test_reset();
    w[0] = 32'h2001_0005;
    w[1] = 32'h2002_0007;
    test_load(2, w);
    test_edge_cmds();
    test_step(32'h4);
    for (int i = 0; i < 16; i++) w[i] = $urandom;
    test_load($urandom_range(3, 16), w);
    test_run(10);
    test_run($urandom_range(4, 30));
    test_step($urandom);
    test_dump_random_ready();
    test_backpressure();
    test_reset_mid_send();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
